fb_arbiter: RTL and testbench
=============================

# fb_arbiter

Arbiter and sequencer for the single-port 128 x 96 x 8 frame-buffer RAM. It shares one synchronous-read memory port between three requesters: the VGA scanout reader, a host write port and a host read port. Scanout always wins so the display never tears. The two host ports share the remaining slots round-robin. The block sits between the pixel-clock VGA timing/scanout logic and the frame-buffer RAM, in the 25.125 MHz PLL clock domain.

## Interface
- `ADDR_W`, 14, address width (words).
- `DATA_W`, 8, data width; bits [7:2] carry RRGGBB colour.
- `DEPTH`, 12288, valid words (128 x 96); addresses >= DEPTH are out of range.
- `STARVE_MAX`, 1023, host wait cycles before the starve flag sets; 10-bit counter.
- `clk`  in  1  PLL pixel clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `scan_req`  in  1  scanout read request (highest priority).
- `scan_addr`  in  ADDR_W  scanout address.
- `scan_data`  out  DATA_W  scanout read data.
- `scan_valid`  out  1  one-cycle strobe, scan_data valid.
- `wr_valid` / `wr_ready`  in / out  1  host write handshake.
- `wr_addr`, `wr_data`  in  ADDR_W, DATA_W  host write command.
- `rd_valid` / `rd_ready`  in / out  1  host read handshake.
- `rd_addr`  in  ADDR_W  host read address.
- `rd_data`  out  DATA_W  host read data.
- `rd_data_valid`  out  1  one-cycle strobe, rd_data valid.
- `mem_en`, `mem_we`  out  1  RAM enable and write enable.
- `mem_addr`, `mem_wdata`  out  ADDR_W, DATA_W  RAM command.
- `mem_rdata`  in  DATA_W  RAM read data, valid one cycle after the enabled read.
- `starve`  out  1  sticky flag; a host request waited more than STARVE_MAX cycles.
- `starve_clr`  in  1  clears `starve`.

## Operation
- Grant is combinational each cycle, in priority order scan > host, then round-robin between wr and rd.
  - `scan_req`=1: scan granted; `wr_ready`=`rd_ready`=0.
  - Otherwise, if only one host port is valid, it is granted.
  - If both host ports are valid, grant the port not granted last. `last_host` register resets to RD, so the first contest goes to WR.
- A transfer completes when valid && ready. `last_host` updates only on a completed host transfer.
- Ready may depend on valid. Host ports hold command stable until ready.
- Command register: the granted command is registered into `mem_*` on the clock edge closing the grant cycle. `mem_en`=0 when nothing is granted.
- Out of range (addr >= DEPTH):
  - Write: acknowledged and dropped; `mem_en`=0.
  - Read: acknowledged; read data returned as 0 with the normal latency and strobe.
  - Scan: returns 0 with the normal latency.
- Read tag pipeline: 2 stages, each holding {src: NONE/SCAN/RD, oor}. On stage-2 exit, `mem_rdata` (or 0 if oor) is registered into `scan_data` or `rd_data`, and the matching strobe pulses. The other data output holds its last value.
- Starve counter:
  - Counts cycles where (`wr_valid` or `rd_valid`) and no host grant.
  - Resets to 0 on any host grant or when no host request is pending.
  - Saturates at STARVE_MAX; reaching STARVE_MAX sets `starve`.
  - `starve_clr` clears the flag. If set and clear occur in the same cycle, set wins.

## Timing
- Request granted in cycle T: `mem_*` driven in T+1; `mem_rdata` valid in T+2; `scan_data`/`rd_data` and strobe valid in T+3.
- Read latency is fixed at 3 cycles. Throughput is 1 access per cycle with no bubbles.
- A write granted in T reaches the RAM in T+1. A read granted in T+1 or later to the same address returns the new data.
- Back-to-back scan requests every cycle fully block the host; `starve` then sets after STARVE_MAX+1 stalled cycles.
- Reset (async, any time) forces:
  - outputs `mem_en`, `mem_we`, `scan_valid`, `rd_data_valid`, `starve` = 0;
  - `mem_addr`, `mem_wdata`, `scan_data`, `rd_data` = 0;
  - pipeline tags = NONE, `last_host` = RD, starve counter = 0.
- Reads in flight at reset are discarded; no strobes after reset release until a new grant.

## Test plan
- Scan only: `scan_req` at T with addr 5, RAM[5]=0xA4 -> `scan_valid` at T+3, `scan_data`=0xA4, exactly one strobe.
- Contention: `scan_req`, `wr_valid` and `rd_valid` all high for 1 cycle, then both host ports held -> scan first; then WR, RD, WR alternating; `wr_ready`/`rd_ready` never high while `scan_req`=1.
- Read-after-write: write 0x3C to 100 at T, read 100 at T+1 -> `rd_data_valid` at T+4 with 0x3C.
- Out of range: write to 12288 -> acknowledged, `mem_en` stays 0; read of 12300 -> `rd_data`=0 after 3 cycles.
- Starvation: `scan_req` held high 1100 cycles with `wr_valid`=1 -> `starve` rises after 1024 stalled cycles and stays set; `starve_clr` pulse after `scan_req` drops -> 0.
- Reset mid-read: assert `rst_n`=0 one cycle after a read grant -> all outputs 0 immediately, no `rd_data_valid` afterwards.

Source files
------------

// File: rtl/fb_arbiter_if.sv
// -----------------------------------------------------------------------------
// fb_arbiter_if
// Bundles every frame-buffer arbiter signal except clock and reset: the
// scanout read channel, the host write and host read handshakes, the RAM
// command/response port and the starve flag.
//   master : the surrounding system (scanout, host, RAM model) drives requests
//            and mem_rdata, and receives the responses.
//   slave  : the arbiter itself.
// -----------------------------------------------------------------------------
interface fb_arbiter_if #(
   parameter int ADDR_W = 14,
   parameter int DATA_W = 8
);
   // scanout channel
   logic              scan_req;
   logic [ADDR_W-1:0] scan_addr;
   logic [DATA_W-1:0] scan_data;
   logic              scan_valid;
   // host write channel
   logic              wr_valid;
   logic              wr_ready;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   // host read channel
   logic              rd_valid;
   logic              rd_ready;
   logic [ADDR_W-1:0] rd_addr;
   logic [DATA_W-1:0] rd_data;
   logic              rd_data_valid;
   // RAM port
   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   // starvation monitor
   logic              starve;
   logic              starve_clr;

   modport master (
      output scan_req, scan_addr, wr_valid, wr_addr, wr_data,
             rd_valid, rd_addr, mem_rdata, starve_clr,
      input  scan_data, scan_valid, wr_ready, rd_ready, rd_data,
             rd_data_valid, mem_en, mem_we, mem_addr, mem_wdata, starve
   );

   modport slave (
      input  scan_req, scan_addr, wr_valid, wr_addr, wr_data,
             rd_valid, rd_addr, mem_rdata, starve_clr,
      output scan_data, scan_valid, wr_ready, rd_ready, rd_data,
             rd_data_valid, mem_en, mem_we, mem_addr, mem_wdata, starve
   );
endinterface

// File: rtl/fb_arbiter.sv
// -----------------------------------------------------------------------------
// fb_arbiter
// Shares the single-port 128x96x8 frame-buffer RAM between VGA scanout (always
// wins), a host write port and a host read port (round-robin between them).
// Grant is combinational; the granted command is registered onto the RAM port
// one cycle later, and read data comes back on scan_data / rd_data with a
// fixed 3-cycle latency and a one-cycle strobe.
// Ports:
//   clk   : PLL pixel clock
//   rst_n : asynchronous active-low reset
//   bus   : fb_arbiter_if.slave (scanout, host wr/rd, RAM port, starve flag)
// -----------------------------------------------------------------------------
module fb_arbiter #(
   parameter int ADDR_W     = 14,
   parameter int DATA_W     = 8,
   parameter int DEPTH      = 12288,
   parameter int STARVE_MAX = 1023
) (
   input logic         clk,
   input logic         rst_n,
   fb_arbiter_if.slave bus
);

   localparam logic [ADDR_W-1:0] DEPTH_A    = ADDR_W'(DEPTH);
   localparam logic [9:0]        STARVE_LIM = 10'(STARVE_MAX);

   typedef enum logic       {HOST_WR, HOST_RD} host_e;
   typedef enum logic [1:0] {SRC_NONE, SRC_SCAN, SRC_RD} src_e;
   typedef struct packed {
      src_e src;
      logic oor;
   } tag_t;

   host_e      last_host;
   tag_t       tag1, tag2;
   logic [9:0] starve_cnt;

   logic scan_gnt, wr_gnt, rd_gnt;
   logic scan_oor, wr_oor, rd_oor;
   logic host_stall;

   // Grant: scan first, then the host port that did not win last time when
   // both are asking. last_host resets to RD so the first contest goes to WR.
   assign scan_gnt = bus.scan_req;
   assign wr_gnt   = !bus.scan_req && bus.wr_valid &&
                     (!bus.rd_valid || last_host == HOST_RD);
   assign rd_gnt   = !bus.scan_req && bus.rd_valid &&
                     (!bus.wr_valid || last_host == HOST_WR);

   assign bus.wr_ready = wr_gnt;
   assign bus.rd_ready = rd_gnt;

   assign scan_oor = bus.scan_addr >= DEPTH_A;
   assign wr_oor   = bus.wr_addr   >= DEPTH_A;
   assign rd_oor   = bus.rd_addr   >= DEPTH_A;

   // A host is waiting but neither host port won this cycle.
   assign host_stall = (bus.wr_valid || bus.rd_valid) && !(wr_gnt || rd_gnt);

   // Command register and stage-1 read tag. Out-of-range accesses never reach
   // the RAM; reads among them still carry a tag so data returns as 0 on time.
   // NOTE: sequential state uses non-blocking (<=) so every register samples
   // the pre-edge value of every other register, independent of block order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.mem_en    <= 1'b0;
         bus.mem_we    <= 1'b0;
         bus.mem_addr  <= '0;
         bus.mem_wdata <= '0;
         tag1          <= '{src: SRC_NONE, oor: 1'b0};
         last_host     <= HOST_RD;
      end else begin
         bus.mem_en <= 1'b0;
         bus.mem_we <= 1'b0;
         tag1       <= '{src: SRC_NONE, oor: 1'b0};
         if (scan_gnt) begin
            bus.mem_en   <= !scan_oor;
            bus.mem_addr <= bus.scan_addr;
            tag1         <= '{src: SRC_SCAN, oor: scan_oor};
         end else if (wr_gnt) begin
            bus.mem_en    <= !wr_oor;
            bus.mem_we    <= !wr_oor;
            bus.mem_addr  <= bus.wr_addr;
            bus.mem_wdata <= bus.wr_data;
            last_host     <= HOST_WR;
         end else if (rd_gnt) begin
            bus.mem_en   <= !rd_oor;
            bus.mem_addr <= bus.rd_addr;
            tag1         <= '{src: SRC_RD, oor: rd_oor};
            last_host    <= HOST_RD;
         end
      end
   end

   // Stage-2 tag lines up with mem_rdata; on exit the data is registered into
   // the output selected by the tag, the other output keeps its last value.
   // NOTE: the tag pipeline is reset to NONE so reads in flight at reset are
   // dropped and never produce a strobe afterwards.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tag2              <= '{src: SRC_NONE, oor: 1'b0};
         bus.scan_data     <= '0;
         bus.scan_valid    <= 1'b0;
         bus.rd_data       <= '0;
         bus.rd_data_valid <= 1'b0;
      end else begin
         tag2              <= tag1;
         bus.scan_valid    <= 1'b0;
         bus.rd_data_valid <= 1'b0;
         case (tag2.src)
            SRC_SCAN: begin
               bus.scan_valid <= 1'b1;
               bus.scan_data  <= tag2.oor ? {DATA_W{1'b0}} : bus.mem_rdata;
            end
            SRC_RD: begin
               bus.rd_data_valid <= 1'b1;
               bus.rd_data       <= tag2.oor ? {DATA_W{1'b0}} : bus.mem_rdata;
            end
            default: ;
         endcase
      end
   end

   // Starvation watch: count consecutive stalled host cycles, saturate at the
   // limit, and set the sticky flag on a stalled cycle that finds the counter
   // already saturated (i.e. after STARVE_MAX+1 stalls). Set beats clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         starve_cnt <= '0;
         bus.starve <= 1'b0;
      end else begin
         if (!host_stall) begin
            starve_cnt <= '0;
         end else if (starve_cnt != STARVE_LIM) begin
            starve_cnt <= starve_cnt + 10'd1;
         end

         if (host_stall && starve_cnt == STARVE_LIM) begin
            bus.starve <= 1'b1;
         end else if (bus.starve_clr) begin
            bus.starve <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_fb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fb_arbiter
// Directed stimulus for fb_arbiter with a behavioural synchronous-read RAM.
// Issuing tasks push the expected data and arrival cycle into per-channel
// queues; a negedge monitor pops and compares whenever a strobe appears.
// -----------------------------------------------------------------------------
module tb_fb_arbiter;
   localparam int ADDR_W = 14;
   localparam int DATA_W = 8;
   localparam int DEPTH  = 12288;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;

   fb_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   fb_arbiter #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .STARVE_MAX(1023)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   // Synchronous-read RAM; out-of-range addresses read a poison value so a
   // stray access shows up as a data error.
   logic [7:0] ram [0:DEPTH-1];
   always @(posedge clk) begin
      if (bus.mem_en) begin
         if (bus.mem_we) begin
            if (int'(bus.mem_addr) < DEPTH) ram[bus.mem_addr] <= bus.mem_wdata;
         end else begin
            bus.mem_rdata <= (int'(bus.mem_addr) < DEPTH) ? ram[bus.mem_addr] : 8'hEE;
         end
      end
   end

   typedef struct {
      logic [7:0] data;
      int         due;
   } exp_t;

   exp_t scan_q[$];
   exp_t rd_q[$];
   exp_t e_scan, e_rd;
   int   n_cmp      = 0;
   int   n_fail     = 0;
   int   rd_strobes = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, wanted 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: compare every strobe against the head of its queue.
   always @(negedge clk) begin
      if (bus.scan_valid) begin
         if (scan_q.size() == 0) begin
            check("scan_unexpected_strobe", 32'(bus.scan_valid), 0);
         end else begin
            e_scan = scan_q.pop_front();
            check("scan_data", 32'(bus.scan_data), 32'(e_scan.data));
            check("scan_latency", cyc, e_scan.due);
         end
      end
      if (bus.rd_data_valid) begin
         rd_strobes++;
         if (rd_q.size() == 0) begin
            check("rd_unexpected_strobe", 32'(bus.rd_data_valid), 0);
         end else begin
            e_rd = rd_q.pop_front();
            check("rd_data", 32'(bus.rd_data), 32'(e_rd.data));
            check("rd_latency", cyc, e_rd.due);
         end
      end
      if (bus.scan_req && (bus.wr_valid || bus.rd_valid))
         check("host_ready_during_scan", {30'd0, bus.wr_ready, bus.rd_ready}, 0);
   end

   // All issuing tasks start just after a rising edge and return just after one.
   task automatic scan_read(input logic [13:0] a, input logic [7:0] exp);
      bus.scan_req  = 1'b1;
      bus.scan_addr = a;
      @(negedge clk);
      scan_q.push_back('{data: exp, due: cyc + 3});
      @(posedge clk); #1;
      bus.scan_req = 1'b0;
   endtask

   task automatic host_write(input logic [13:0] a, input logic [7:0] d, output int acc);
      bus.wr_valid = 1'b1;
      bus.wr_addr  = a;
      bus.wr_data  = d;
      acc = -1;
      for (int i = 0; i < 2000 && acc < 0; i++) begin
         @(negedge clk);
         if (bus.wr_ready) acc = cyc;
         @(posedge clk); #1;
      end
      bus.wr_valid = 1'b0;
      if (acc < 0) begin
         n_cmp++;
         n_fail++;
         $display("FAIL wr_accept_timeout: addr 0x%0h never got wr_ready", a);
      end
   endtask

   task automatic host_read(input logic [13:0] a, input logic [7:0] exp, output int acc);
      bus.rd_valid = 1'b1;
      bus.rd_addr  = a;
      acc = -1;
      for (int i = 0; i < 2000 && acc < 0; i++) begin
         @(negedge clk);
         if (bus.rd_ready) begin
            acc = cyc;
            rd_q.push_back('{data: exp, due: cyc + 3});
         end
         @(posedge clk); #1;
      end
      bus.rd_valid = 1'b0;
      if (acc < 0) begin
         n_cmp++;
         n_fail++;
         $display("FAIL rd_accept_timeout: addr 0x%0h never got rd_ready", a);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   int t0, a1, a2, r1, r2, rd_before;

   initial begin
      bus.scan_req   = 1'b0;
      bus.scan_addr  = '0;
      bus.wr_valid   = 1'b0;
      bus.wr_addr    = '0;
      bus.wr_data    = '0;
      bus.rd_valid   = 1'b0;
      bus.rd_addr    = '0;
      bus.starve_clr = 1'b0;
      for (int i = 0; i < DEPTH; i++) ram[i] = 8'h0F;
      ram[5]     = 8'hA4;
      ram[6]     = 8'h18;
      ram[200]   = 8'h55;
      ram[201]   = 8'h66;
      ram[12287] = 8'hFC;

      // Reset state
      rst_n = 1'b0;
      idle(3);
      check("reset_flags", {27'd0, bus.mem_en, bus.mem_we, bus.scan_valid,
                            bus.rd_data_valid, bus.starve}, 0);
      check("reset_mem_addr", 32'(bus.mem_addr), 0);
      check("reset_mem_wdata", 32'(bus.mem_wdata), 0);
      check("reset_data_out", {16'd0, bus.scan_data, bus.rd_data}, 0);
      rst_n = 1'b1;
      idle(2);

      // Scan only: one strobe, 3 cycles later
      scan_read(14'd5, 8'hA4);
      idle(5);

      // Contention: scan wins, then WR, RD, WR, RD
      t0 = cyc;
      fork
         scan_read(14'd6, 8'h18);
         begin
            host_write(14'd300, 8'h11, a1);
            host_write(14'd301, 8'h22, a2);
         end
         begin
            host_read(14'd200, 8'h55, r1);
            host_read(14'd201, 8'h66, r2);
         end
      join
      check("cont_wr1_cycle", a1 - t0, 1);
      check("cont_rd1_cycle", r1 - t0, 2);
      check("cont_wr2_cycle", a2 - t0, 3);
      check("cont_rd2_cycle", r2 - t0, 4);
      host_read(14'd300, 8'h11, r1);
      host_read(14'd301, 8'h22, r1);
      idle(5);

      // Read-after-write on consecutive cycles
      host_write(14'd100, 8'h3C, a1);
      check("wr_cmd", {8'd0, bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata},
            {8'd0, 1'b1, 1'b1, 14'd100, 8'h3C});
      host_read(14'd100, 8'h3C, r1);
      check("raw_gap", r1 - a1, 1);
      idle(5);

      // Out of range and the last valid word
      host_write(14'd12288, 8'h77, a1);
      check("oor_wr_mem_en", 32'(bus.mem_en), 0);
      host_read(14'd12300, 8'h00, r1);
      host_read(14'd12288, 8'h00, r1);
      host_read(14'd12287, 8'hFC, r1);
      scan_read(14'd12500, 8'h00);
      idle(5);

      // Starvation: scan every cycle for 1100 cycles while a write waits
      t0 = cyc;
      fork
         host_write(14'd400, 8'h99, a1);
         begin
            for (int i = 0; i < 1100; i++) begin
               bus.scan_req  = 1'b1;
               bus.scan_addr = 14'd5;
               @(negedge clk);
               scan_q.push_back('{data: 8'hA4, due: cyc + 3});
               if (i == 1023) check("starve_before_limit", 32'(bus.starve), 0);
               if (i == 1024) check("starve_at_limit", 32'(bus.starve), 1);
               if (i == 1099) check("starve_held", 32'(bus.starve), 1);
               @(posedge clk); #1;
            end
            bus.scan_req = 1'b0;
         end
      join
      check("starve_wr_grant_cycle", a1 - t0, 1100);
      check("starve_sticky", 32'(bus.starve), 1);
      bus.starve_clr = 1'b1;
      idle(1);
      bus.starve_clr = 1'b0;
      check("starve_cleared", 32'(bus.starve), 0);
      host_read(14'd400, 8'h99, r1);
      idle(5);

      // Reset one cycle after a read grant: everything clears, no strobe later
      rd_before    = rd_strobes;
      bus.rd_valid = 1'b1;
      bus.rd_addr  = 14'd5;
      @(negedge clk);
      check("rst_rd_granted", 32'(bus.rd_ready), 1);
      @(posedge clk); #1;
      bus.rd_valid = 1'b0;
      check("rst_rd_cmd_issued", 32'(bus.mem_en), 1);
      rst_n = 1'b0;
      #1;
      check("rst_mid_flags", {27'd0, bus.mem_en, bus.mem_we, bus.scan_valid,
                              bus.rd_data_valid, bus.starve}, 0);
      check("rst_mid_mem_addr", 32'(bus.mem_addr), 0);
      check("rst_mid_data_out", {16'd0, bus.scan_data, bus.rd_data}, 0);
      idle(2);
      rst_n = 1'b1;
      idle(8);
      check("rst_no_stale_strobe", rd_strobes, rd_before);

      // First contest after reset goes to WR
      t0 = cyc;
      fork
         host_write(14'd500, 8'h42, a1);
         host_read(14'd5, 8'hA4, r1);
      join
      check("post_rst_wr_first", a1 - t0, 0);
      check("post_rst_rd_second", r1 - t0, 1);
      host_read(14'd500, 8'h42, r1);
      idle(6);

      check("scan_queue_drained", scan_q.size(), 0);
      check("rd_queue_drained", rd_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
